// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared sizes and write-back request type for the register file arbiter
package rf_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with a registered last-grant pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic       o_xfer
);
  // 1 means requester 1 won the most recent transfer, so requester 0 wins the first tie
  logic r_last;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (rst_n) begin
      if (i_req[0] && i_req[1]) begin
        w_gnt = r_last ? 2'b01 : 2'b10;
      end else begin
        w_gnt = i_req;
      end
    end
  end

  assign o_gnt  = w_gnt;
  assign o_xfer = |w_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (|w_gnt) begin
      r_last <= w_gnt[1];
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - shares the register file write port between two write-back sources and tracks pending writes
module rf_wb_arbiter import rf_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                rsv_ready,
  input  logic [ADDR_W-1:0]   rs_addr,
  input  logic [ADDR_W-1:0]   rt_addr,
  output logic                rs_busy,
  output logic                rt_busy,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] busy_vec
);
  wb_req_t w_req0;
  wb_req_t w_req1;
  logic [1:0]          w_gnt;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_rsv_ok;
  logic [NUM_REGS-1:0] w_busy_next;

  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [NUM_REGS-1:0] r_busy;

  assign w_req0 = '{valid: req0_valid, addr: req0_addr, data: req0_data};
  assign w_req1 = '{valid: req1_valid, addr: req1_addr, data: req1_data};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  ({w_req1.valid, w_req0.valid}),
    .o_gnt  (w_gnt),
    .o_xfer (w_xfer)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign w_waddr    = w_gnt[1] ? w_req1.addr : w_req0.addr;
  assign w_wdata    = w_gnt[1] ? w_req1.data : w_req0.data;

  // A write-back retiring the same register this cycle frees it for a new reservation
  assign w_rsv_ok  = !r_busy[rsv_addr] || (w_xfer && (w_waddr == rsv_addr));
  assign rsv_ready = rst_n && w_rsv_ok;

  always_comb begin
    w_busy_next = r_busy;
    if (w_xfer) begin
      w_busy_next[w_waddr] = 1'b0;
    end
    if (rsv_valid && rsv_ready && (rsv_addr != ZERO_REG)) begin
      w_busy_next[rsv_addr] = 1'b1;
    end
    w_busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
    end else begin
      r_we   <= w_xfer && (w_waddr != ZERO_REG);
      r_busy <= w_busy_next;
      if (w_xfer) begin
        r_waddr <= w_waddr;
        r_wdata <= w_wdata;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign busy_vec = r_busy;
  assign rs_busy  = (rs_addr != ZERO_REG) && r_busy[rs_addr];
  assign rt_busy  = (rt_addr != ZERO_REG) && r_busy[rt_addr];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed and randomized checks of the write-back arbiter against a reference model
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsv_valid;
  logic [4:0]  req0_addr, req1_addr, rsv_addr, rs_addr, rt_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, rsv_ready, rs_busy, rt_busy, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, busy_vec;

  int tests = 0;
  int fails = 0;

  // reference state: set of pending registers, last winner, what the RF port shows
  logic [31:0] m_busy;
  int          m_last;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          obs_r0, obs_r1, obs_rv;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 32'h0; m_last = 1; m_we = 0; m_waddr = 5'd0; m_wdata = 32'h0;
  endtask

  // one cycle: check outputs against the model, then advance the model over the rising edge
  task automatic step();
    bit g0, g1, xf, rv;
    logic [4:0]  wa;
    logic [31:0] wd;
    #1;
    g0 = 0; g1 = 0; rv = 0;
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
        g0 = (m_last == 1);
        g1 = !g0;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
    xf = g0 | g1;
    wa = g1 ? req1_addr : req0_addr;
    wd = g1 ? req1_data : req0_data;
    if (rst_n) rv = !m_busy[rsv_addr] || (xf && wa == rsv_addr);
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("rsv_ready", rsv_ready, rv);
    chk("rs_busy", rs_busy, m_busy[rs_addr]);
    chk("rt_busy", rt_busy, m_busy[rt_addr]);
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("busy_vec", busy_vec, m_busy);
    obs_r0 = req0_ready; obs_r1 = req1_ready; obs_rv = rsv_ready;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_we = 0;
      if (xf) begin
        m_we = (wa != 0);
        m_waddr = wa;
        m_wdata = wd;
        m_last = g1 ? 1 : 0;
        m_busy[wa] = 1'b0;
      end
      if (rsv_valid && rv && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; rsv_valid = 0;
  endtask

  initial begin
    rst_n = 0; idle();
    req0_addr = 0; req1_addr = 0; rsv_addr = 0; rs_addr = 0; rt_addr = 0;
    req0_data = 0; req1_data = 0;
    @(posedge clk); @(negedge clk);
    model_reset();
    step();
    chk("reset_rf_we", rf_we, 0);
    chk("reset_busy_vec", busy_vec, 0);
    rst_n = 1;

    // single write
    req0_valid = 1; req0_addr = 5; req0_data = 32'h1234_5678;
    step();
    chk("t1_ready", obs_r0, 1);
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'h1234_5678);
    idle();
    step();
    chk("t1_we_drop", rf_we, 0);

    // round-robin from reset
    rst_n = 0; step(); rst_n = 1;
    req0_valid = 1; req0_addr = 3; req0_data = 32'hA;
    req1_valid = 1; req1_addr = 4; req1_data = 32'hB;
    step();
    chk("t2_g0", {obs_r1, obs_r0}, 2'b01);
    chk("t2_addr3", rf_waddr, 3);
    step();
    chk("t2_g1", {obs_r1, obs_r0}, 2'b10);
    chk("t2_addr4", rf_waddr, 4);
    chk("t2_we4", rf_we, 1);
    step();
    chk("t2_g0b", {obs_r1, obs_r0}, 2'b01);
    idle();

    // scoreboard
    rsv_valid = 1; rsv_addr = 7;
    step();
    chk("t3_rsv1", obs_rv, 1);
    chk("t3_busy7", busy_vec[7], 1);
    rs_addr = 7; #1;
    chk("t3_rs_busy", rs_busy, 1);
    step();
    chk("t3_rsv_block", obs_rv, 0);
    req1_valid = 1; req1_addr = 7; req1_data = 32'hCAFE_0007;
    step();
    chk("t3_wb_ready", obs_r1, 1);
    chk("t3_rersv", obs_rv, 1);
    chk("t3_busy_kept", busy_vec[7], 1);
    chk("t3_waddr", rf_waddr, 7);
    idle();

    // register zero
    rsv_valid = 1; rsv_addr = 0;
    req0_valid = 1; req0_addr = 0; req0_data = 32'hFFFF_FFFF;
    step();
    chk("t4_rsv0", obs_rv, 1);
    chk("t4_req0", obs_r0, 1);
    chk("t4_busy0", busy_vec[0], 0);
    chk("t4_we", rf_we, 0);
    idle(); rs_addr = 0; #1;
    chk("t4_rs_busy0", rs_busy, 0);

    // reset mid-operation
    rsv_valid = 1; rsv_addr = 9;
    req0_valid = 1; req0_addr = 10; req0_data = 32'h5A5A_0010;
    step();
    chk("t5_busy9", busy_vec[9], 1);
    chk("t5_we", rf_we, 1);
    req1_valid = 1; req1_addr = 11; req1_data = 32'h11;
    rst_n = 0;
    step();
    chk("t5_rdy_rst", {obs_rv, obs_r1, obs_r0}, 3'b000);
    chk("t5_we_rst", rf_we, 0);
    chk("t5_busy_rst", busy_vec, 0);
    rst_n = 1; rsv_valid = 0;
    step();
    chk("t5_tie_after_rst", {obs_r1, obs_r0}, 2'b01);

    // randomized traffic, honouring the hold-until-ready rule
    for (int i = 0; i < 400; i++) begin
      if (!(req0_valid && !obs_r0 && rst_n)) begin
        req0_valid = $urandom_range(0, 1);
        req0_addr = $urandom_range(0, 7);
        req0_data = $urandom;
      end
      if (!(req1_valid && !obs_r1 && rst_n)) begin
        req1_valid = $urandom_range(0, 1);
        req1_addr = $urandom_range(0, 7);
        req1_data = $urandom;
      end
      rsv_valid = $urandom_range(0, 1);
      rsv_addr = $urandom_range(0, 7);
      rs_addr = $urandom_range(0, 7);
      rt_addr = $urandom_range(0, 7);
      rst_n = ($urandom_range(0, 39) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
